// File: rtl/bit_nibble_fifo_ctrl.sv
// Bit-in / nibble-out FIFO controller for an external 4096x1 / 1024x4
// dual-port RAM. Single bits are written through port A; four stored bits
// are read as one nibble through port B with one cycle of read latency.
module bit_nibble_fifo_ctrl #(
  parameter int AF_LEVEL = 4032
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        wr_en,
  input  logic        wr_data,
  input  logic        rd_en,
  output logic [3:0]  rd_data,
  output logic        rd_valid,
  output logic        full,
  output logic        almost_full,
  output logic        empty,
  output logic [12:0] count,
  output logic        wr_err,
  output logic        rd_err,
  output logic [11:0] addra,
  output logic        dia,
  output logic        ena,
  output logic        wea,
  output logic [9:0]  addrb,
  output logic        enb,
  output logic        web,
  input  logic [3:0]  dob
);

  localparam logic [12:0] AF_CNT = 13'(AF_LEVEL);

  logic [11:0] wptr;
  logic [9:0]  rptr;
  logic        wr_acc;
  logic        rd_acc;
  logic        vld_p1;

  // Accept decisions and RAM port drive; flush and reset suppress both ports.
  always_comb begin
    wr_acc  = wr_en & ~full  & ~flush & ~rst;
    rd_acc  = rd_en & ~empty & ~flush & ~rst;
    ena     = wr_acc;
    wea     = wr_acc;
    addra   = wptr;
    dia     = wr_data;
    enb     = rd_acc;
    addrb   = rptr;
    web     = 1'b0;
  end

  // Status flags decoded from the registered bit count.
  always_comb begin
    full        = (count == 13'd4096);
    empty       = (count < 13'd4);
    almost_full = (count >= AF_CNT);
  end

  // Pointer and count update; flush clears them and overrides any access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + 12'd1;
      if (rd_acc) rptr <= rptr + 10'd1;
      count <= count + 13'(wr_acc) - (rd_acc ? 13'd4 : 13'd0);
    end
  end

  // Sticky overflow/underflow flags, left untouched by flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_err <= 1'b0;
      rd_err <= 1'b0;
    end else if (!flush) begin
      if (wr_en && full)  wr_err <= 1'b1;
      if (rd_en && empty) rd_err <= 1'b1;
    end
  end

  // ---- stage p0 -> p1: RAM read cycle, nibble valid on the following cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= rd_acc;
  end

  assign rd_valid = vld_p1;
  assign rd_data  = dob;

endmodule

// File: tb/tb_bit_nibble_fifo_ctrl.sv
// Testbench for bit_nibble_fifo_ctrl: behavioural dual-port RAM, directed
// stimulus, and a scoreboard queue of expected nibbles drained by a monitor.
module tb_bit_nibble_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst, flush, wr_en, wr_data, rd_en;
  logic [3:0]  rd_data;
  logic        rd_valid, full, almost_full, empty;
  logic [12:0] count;
  logic        wr_err, rd_err;
  logic [11:0] addra;
  logic        dia, ena, wea;
  logic [9:0]  addrb;
  logic        enb, web;
  logic [3:0]  dob = 4'd0;

  logic [4095:0] mem;

  int checks = 0;
  int errors = 0;

  int   m_count, m_wptr, m_rptr;
  logic m_werr, m_rerr;
  bit   refq[$];
  logic [3:0] sbq[$];
  logic       stim_done = 1'b0;

  always #5 clk = ~clk;

  bit_nibble_fifo_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .full(full),
    .almost_full(almost_full), .empty(empty), .count(count),
    .wr_err(wr_err), .rd_err(rd_err), .addra(addra), .dia(dia), .ena(ena),
    .wea(wea), .addrb(addrb), .enb(enb), .web(web), .dob(dob)
  );

  // 4096x1 write port, 1024x4 registered read port
  always @(posedge clk) begin
    if (ena && wea) mem[addra] <= dia;
    if (enb) dob <= mem[{addrb, 2'b00} +: 4];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_status();
    chk("count", 32'(count), 32'(m_count));
    chk("full", 32'(full), 32'(m_count == 4096));
    chk("empty", 32'(empty), 32'(m_count < 4));
    chk("almost_full", 32'(almost_full), 32'(m_count >= 4032));
    chk("wr_err", 32'(wr_err), 32'(m_werr));
    chk("rd_err", 32'(rd_err), 32'(m_rerr));
  endtask

  task automatic model_reset();
    m_count = 0; m_wptr = 0; m_rptr = 0;
    m_werr = 1'b0; m_rerr = 1'b0;
    refq.delete();
  endtask

  // Called at a negedge: drive inputs, check the combinational RAM drive,
  // cross one rising edge, then check the registered status.
  task automatic do_op(input logic w, input logic wd, input logic r);
    bit wacc, racc;
    logic [3:0] nib;
    wr_en = w; wr_data = wd; rd_en = r; flush = 1'b0;
    #1;
    wacc = w && (m_count != 4096);
    racc = r && (m_count >= 4);
    chk("ena", 32'(ena), 32'(wacc));
    chk("wea", 32'(wea), 32'(wacc));
    chk("enb", 32'(enb), 32'(racc));
    chk("web", 32'(web), 32'(0));
    if (wacc) begin
      chk("addra", 32'(addra), 32'(m_wptr));
      chk("dia", 32'(dia), 32'(wd));
    end
    if (racc) begin
      chk("addrb", 32'(addrb), 32'(m_rptr));
      for (int k = 0; k < 4; k++) nib[k] = refq.pop_front();
      sbq.push_back(nib);
    end
    if (wacc) refq.push_back(wd);
    if (w && !wacc) m_werr = 1'b1;
    if (r && !racc) m_rerr = 1'b1;
    m_count = m_count + int'(wacc) - 4 * int'(racc);
    m_wptr  = (m_wptr + int'(wacc)) % 4096;
    m_rptr  = (m_rptr + int'(racc)) % 1024;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    chk_status();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; wr_en = 1'b1; wr_data = 1'b1; rd_en = 1'b1;
    model_reset();
    fork
      begin : stim
        // reset state, with both request strobes held high
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ena", 32'(ena), 32'(0));
        chk("rst_enb", 32'(enb), 32'(0));
        chk("rst_count", 32'(count), 32'(0));
        chk("rst_empty", 32'(empty), 32'(1));
        chk("rst_full", 32'(full), 32'(0));
        chk("rst_af", 32'(almost_full), 32'(0));
        chk("rst_rd_valid", 32'(rd_valid), 32'(0));
        chk("rst_errs", 32'({wr_err, rd_err}), 32'(0));
        @(negedge clk);
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;

        // bits 1,0,1,1 then one nibble read
        do_op(1'b1, 1'b1, 1'b0);
        do_op(1'b1, 1'b0, 1'b0);
        do_op(1'b1, 1'b1, 1'b0);
        do_op(1'b1, 1'b1, 1'b0);
        do_op(1'b0, 1'b0, 1'b1);
        chk("n0_rd_valid", 32'(rd_valid), 32'(1));
        chk("n0_rd_data", 32'(rd_data), 32'(4'b1101));
        chk("n0_count", 32'(count), 32'(0));
        chk("n0_empty", 32'(empty), 32'(1));

        // underflow with 3 residual bits, then the fourth completes a nibble
        do_op(1'b1, 1'b1, 1'b0);
        do_op(1'b1, 1'b1, 1'b0);
        do_op(1'b1, 1'b0, 1'b0);
        do_op(1'b0, 1'b0, 1'b1);
        chk("uf_rd_err", 32'(rd_err), 32'(1));
        chk("uf_rd_valid", 32'(rd_valid), 32'(0));
        do_op(1'b1, 1'b1, 1'b0);
        chk("uf_count4", 32'(count), 32'(4));
        chk("uf_empty0", 32'(empty), 32'(0));
        do_op(1'b0, 1'b0, 1'b1);
        chk("n1_rd_data", 32'(rd_data), 32'(4'b1011));

        // fill to 4096 (wptr wraps 4095->0), then one overflow write
        for (int i = 0; i < 4096; i++) begin
          logic [12:0] iv;
          iv = 13'(i);
          do_op(1'b1, iv[0] ^ iv[3] ^ iv[7], 1'b0);
          if (i == 4030) chk("af_at_4031", 32'(almost_full), 32'(0));
          if (i == 4031) chk("af_at_4032", 32'(almost_full), 32'(1));
        end
        chk("full_count", 32'(count), 32'(4096));
        chk("full_flag", 32'(full), 32'(1));
        chk("full_wr_err_before", 32'(wr_err), 32'(0));
        do_op(1'b1, 1'b1, 1'b0);
        chk("of_wr_err", 32'(wr_err), 32'(1));
        chk("of_count", 32'(count), 32'(4096));

        // drain to 8 (rptr wraps 1023->0), then 5 cycles of write+read
        for (int i = 0; i < 1022; i++) do_op(1'b0, 1'b0, 1'b1);
        chk("drain_count8", 32'(count), 32'(8));
        do_op(1'b1, 1'b1, 1'b1);
        chk("wr_rd_c5", 32'(count), 32'(5));
        do_op(1'b1, 1'b0, 1'b1);
        chk("wr_rd_c2", 32'(count), 32'(2));
        do_op(1'b1, 1'b1, 1'b1);
        chk("wr_rd_c3", 32'(count), 32'(3));
        do_op(1'b1, 1'b1, 1'b1);
        chk("wr_rd_c4", 32'(count), 32'(4));
        do_op(1'b1, 1'b0, 1'b1);
        chk("wr_rd_c1", 32'(count), 32'(1));
        for (int i = 0; i < 3; i++) do_op(1'b1, 1'(i), 1'b0);
        do_op(1'b0, 1'b0, 1'b1);

        // flush at count 50 with write and read requested
        for (int i = 0; i < 50; i++) do_op(1'b1, 1'(i % 3 == 0), 1'b0);
        chk("pre_flush_count", 32'(count), 32'(50));
        flush = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 1'b1;
        #1;
        chk("flush_ena", 32'(ena), 32'(0));
        chk("flush_enb", 32'(enb), 32'(0));
        @(negedge clk);
        flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        m_count = 0; m_wptr = 0; m_rptr = 0; refq.delete();
        chk("flush_count", 32'(count), 32'(0));
        chk("flush_empty", 32'(empty), 32'(1));
        chk("flush_errs_kept", 32'({wr_err, rd_err}), 32'(2'b11));
        chk("flush_rd_valid", 32'(rd_valid), 32'(0));
        wr_en = 1'b1; #1;
        chk("flush_addra0", 32'(addra), 32'(0));
        do_op(1'b1, 1'b0, 1'b0);

        // asynchronous reset between edges at count 100
        for (int i = 0; i < 103; i++) do_op(1'b1, 1'(i % 5 == 1), 1'b0);
        do_op(1'b0, 1'b0, 1'b1);
        chk("pre_rst_count", 32'(count), 32'(100));
        wr_en = 1'b1; rd_en = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("arst_count", 32'(count), 32'(0));
        chk("arst_empty", 32'(empty), 32'(1));
        chk("arst_rd_valid", 32'(rd_valid), 32'(0));
        chk("arst_errs", 32'({wr_err, rd_err}), 32'(0));
        chk("arst_en", 32'({ena, wea, enb}), 32'(0));
        @(negedge clk);
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        model_reset();
        wr_en = 1'b1; #1;
        chk("post_rst_addra0", 32'(addra), 32'(0));
        do_op(1'b1, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        stim_done = 1'b1;
      end
      begin : monitor
        forever begin
          @(negedge clk);
          if (sbq.size() != 0) begin
            chk("rd_valid_expected", 32'(rd_valid), 32'(1));
            if (rd_valid === 1'b1) begin
              logic [3:0] e;
              e = sbq.pop_front();
              chk("rd_data", 32'(rd_data), 32'(e));
            end
          end else begin
            chk("rd_valid_idle", 32'(rd_valid), 32'(0));
          end
        end
      end
      begin : watchdog
        #2000000;
      end
    join_any
    disable fork;
    chk("stim_done", 32'(stim_done), 32'(1));
    chk("sb_drained", 32'(sbq.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
